// File: rtl/mips_debug_pkg.sv
// Shared debug-path types: dumper state encoding, word geometry and byte order.
// Optional checksum trailer is enabled with MEMDUMP_CHECKSUM_EN.
package mips_debug_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SEND,
      NEXT,
      CKSUM,
      FIN
   } dumpState_t;

   localparam int WORD_BYTES = 4;
   localparam logic [31:0] ADDR_STEP = 32'd4;
   localparam bit DEBUG_TX_MSB_FIRST = 1'b1;

endpackage

// File: rtl/word_serializer.sv
// Holds one captured memory word and hands it out one byte at a time
// over a valid/ready link, most significant byte first.
module word_serializer
   import mips_debug_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic [31:0] word,
   input  logic        ready,
   output logic [7:0]  data,
   output logic        valid,
   output logic        last
);

   logic [31:0] shReg;
   logic [1:0]  idx;
   logic        validReg;
   logic        xfer;

   assign xfer = validReg & ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shReg    <= '0;
         idx      <= '0;
         validReg <= 1'b0;
      end else if (clear) begin
         shReg    <= '0;
         idx      <= '0;
         validReg <= 1'b0;
      end else if (load) begin
         shReg    <= word;
         idx      <= '0;
         validReg <= 1'b1;
      end else if (xfer) begin
         // Shift out the consumed byte so the next one sits in the output slot
         shReg <= DEBUG_TX_MSB_FIRST ? {shReg[23:0], 8'h00}
                                     : {8'h00, shReg[31:8]};
         idx   <= idx + 2'd1;
         if (idx == 2'(WORD_BYTES - 1))
            validReg <= 1'b0;
      end
   end

   assign data  = DEBUG_TX_MSB_FIRST ? shReg[31:24] : shReg[7:0];
   assign valid = validReg;
   assign last  = (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/mem_debug_dumper.sv
// Debug master that stalls the pipeline, walks data memory and streams it
// out as bytes. Define MEMDUMP_CHECKSUM_EN to append an XOR checksum byte.
module mem_debug_dumper
   import mips_debug_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          NUM_WORDS  = 32,
   parameter int          RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        debug_on,
   output logic [31:0] debug_addr,
   input  logic [31:0] mem_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [9:0] LAST_WORD = 10'(NUM_WORDS - 1);
   localparam logic [2:0] LAT_LOAD  = 3'(RD_LATENCY);

   dumpState_t  state;
   dumpState_t  nextState;
   dumpState_t  afterLast;
   logic [2:0]  latCnt;
   logic [9:0]  wordCnt;
   logic [31:0] addrReg;
   logic        serLoad;
   logic        serXfer;
   logic        serLast;
   logic        serValid;
   logic [7:0]  serData;

`ifdef MEMDUMP_CHECKSUM_EN
   assign afterLast = CKSUM;
`else
   assign afterLast = FIN;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (start) nextState = REQ;
         REQ:     nextState = WAIT;
         WAIT:    if (latCnt == 3'd0) nextState = SEND;
         SEND:    if (serXfer && serLast) nextState = NEXT;
         NEXT:    nextState = (wordCnt == LAST_WORD) ? afterLast : REQ;
         CKSUM:   if (tx_ready) nextState = FIN;
         FIN:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (abort)
         nextState = IDLE;
   end

   assign busy     = (state != IDLE) && (state != FIN);
   assign debug_on = busy;
   assign done     = (state == FIN);

   // Address and word count only move between words, so the read port
   // sees a stable address for the whole REQ/WAIT window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addrReg <= BASE_ADDR;
         wordCnt <= '0;
         latCnt  <= '0;
      end else if (abort) begin
         addrReg <= BASE_ADDR;
         wordCnt <= '0;
         latCnt  <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               addrReg <= BASE_ADDR;
               wordCnt <= '0;
            end
            REQ:  latCnt <= LAT_LOAD;
            WAIT: if (latCnt != 3'd0) latCnt <= latCnt - 3'd1;
            NEXT: if (wordCnt != LAST_WORD) begin
               wordCnt <= wordCnt + 10'd1;
               addrReg <= addrReg + ADDR_STEP;
            end
            default: ;
         endcase
      end
   end

   assign debug_addr = addrReg;
   assign serLoad    = (state == WAIT) && (latCnt == 3'd0);
   assign serXfer    = serValid & tx_ready;

   word_serializer u_ser (
      .clk   (clk),
      .rst   (rst),
      .clear (abort),
      .load  (serLoad),
      .word  (mem_data),
      .ready (tx_ready),
      .data  (serData),
      .valid (serValid),
      .last  (serLast)
   );

`ifdef MEMDUMP_CHECKSUM_EN
   logic [7:0] xorAcc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         xorAcc <= '0;
      else if (state == IDLE && start)
         xorAcc <= '0;
      else if (serXfer)
         xorAcc <= xorAcc ^ serData;
   end

   assign tx_data  = (state == CKSUM) ? xorAcc : serData;
   assign tx_valid = serValid | (state == CKSUM);
`else
   assign tx_data  = serData;
   assign tx_valid = serValid;
`endif

endmodule

// File: tb/tb_mem_debug_dumper.sv
// Randomised bench for mem_debug_dumper against a queue-based byte model
// and a latency-accurate memory model.
module tb_mem_debug_dumper;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;
   localparam int NW  = 3;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        debug_on;
   logic [31:0] debug_addr;
   logic [31:0] mem_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] pipe [LAT];

   always #5 clk = ~clk;

   mem_debug_dumper #(
      .BASE_ADDR  (BASE),
      .NUM_WORDS  (NW),
      .RD_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .debug_on   (debug_on),
      .debug_addr (debug_addr),
      .mem_data   (mem_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem.exists(a))
         return mem[a];
      return 32'hBAD0_0000 ^ a;
   endfunction

   // Data appears LAT rising edges after the address is presented
   always @(posedge clk) begin
      pipe[0] <= memRead(debug_addr);
      for (int i = 1; i < LAT; i++)
         pipe[i] <= pipe[i-1];
   end
   assign mem_data = pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chkReset(input string tag);
      chk({tag, "_dbg"}, {31'd0, debug_on}, 0);
      chk({tag, "_addr"}, debug_addr, BASE);
      chk({tag, "_data"}, {24'd0, tx_data}, 0);
      chk({tag, "_valid"}, {31'd0, tx_valid}, 0);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
   endtask

   // mode 0: ready always, 1: ready one cycle in three, 2: random ready
   task automatic runDump(input int mode, input int abortAt,
                          input bit directed);
      logic [7:0]  expQ[$];
      logic [7:0]  gotQ[$];
      logic [31:0] w;
      logic [31:0] dirWords [3];
      logic [7:0]  cks;
      logic [7:0]  prevData;
      bit          prevHold;
      bit          seenDone;
      bit          aborted;
      int          firstValid;
      int          doneCnt;
      int          drop;
      int          abortCyc;

      dirWords[0] = 32'hDEAD_BEEF;
      dirWords[1] = 32'h1122_3344;
      dirWords[2] = 32'hAABB_CCDD;
      cks = 8'h00;
      for (int i = 0; i < NW; i++) begin
         w = directed ? dirWords[i] : $urandom;
         mem[BASE + 32'(4 * i)] = w;
         for (int b = 3; b >= 0; b--) begin
            expQ.push_back(w[8*b +: 8]);
            cks ^= w[8*b +: 8];
         end
      end
`ifdef MEMDUMP_CHECKSUM_EN
      expQ.push_back(cks);
`endif
      prevHold = 0; prevData = 0; seenDone = 0; aborted = 0;
      firstValid = -1; doneCnt = 0; drop = 0; abortCyc = -100;

      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc < 600; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (cyc == 1) begin
            chk("req_busy", {31'd0, busy}, 1);
            chk("req_dbg", {31'd0, debug_on}, 1);
            chk("req_addr", debug_addr, BASE);
         end
         if (prevHold && tx_valid)
            chk("hold", {24'd0, tx_data}, {24'd0, prevData});
         if (tx_valid && firstValid < 0)
            firstValid = cyc;
         if (done) begin
            doneCnt++;
            seenDone = 1;
            chk("fin_dbg", {31'd0, debug_on}, 0);
            chk("fin_busy", {31'd0, busy}, 0);
            chk("fin_len", gotQ.size(), expQ.size());
         end else if (!debug_on && !aborted) begin
            drop++;
         end
         if (aborted && cyc == abortCyc + 1) begin
            chk("abt_dbg", {31'd0, debug_on}, 0);
            chk("abt_valid", {31'd0, tx_valid}, 0);
            chk("abt_busy", {31'd0, busy}, 0);
         end
         if (seenDone || (aborted && cyc > abortCyc + 8))
            break;
         if (abortAt >= 0 && !aborted && gotQ.size() == abortAt) begin
            abort = 1'b1;
            aborted = 1;
            abortCyc = cyc;
         end
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (tx_valid && tx_ready) begin
            if (gotQ.size() % 4 == 0 && gotQ.size() < 4 * NW)
               chk("addr", debug_addr, BASE + 32'(gotQ.size()));
            gotQ.push_back(tx_data);
         end
         prevHold = tx_valid && !tx_ready;
         prevData = tx_data;
      end
      abort = 1'b0;

      if (!aborted) begin
         chk("timeout", {31'd0, seenDone}, 1);
         chk("done_cnt", doneCnt, 1);
         chk("len", gotQ.size(), expQ.size());
         chk("latency", firstValid - 1, LAT + 2);
         chk("dbg_cont", drop, 0);
         if (gotQ.size() == expQ.size())
            for (int i = 0; i < expQ.size(); i++)
               chk($sformatf("byte%0d", i), {24'd0, gotQ[i]}, {24'd0, expQ[i]});
      end else begin
         chk("abt_done", doneCnt, 0);
         chk("abt_len", {31'd0, gotQ.size() >= abortAt}, 1);
         for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            chk($sformatf("abyte%0d", i), {24'd0, gotQ[i]}, {24'd0, expQ[i]});
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      tx_ready = 1'b0;
      #1;
      chkReset("rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      runDump(0, -1, 1);
      runDump(1, -1, 1);
      runDump(2, -1, 0);
      runDump(0, 2, 0);
      runDump(0, -1, 0);

      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", {31'd0, busy}, 0);
      chk("sa_dbg", {31'd0, debug_on}, 0);
      repeat (4) @(negedge clk);
      chk("sa_idle", {31'd0, busy}, 0);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tx_ready = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 1);
      #2 rst = 1'b1;
      #1;
      chkReset("mid");
      @(negedge clk);
      rst = 1'b0;

      runDump(2, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
